// File: rtl/main_memory_arbiter_if.sv
// Bundle of the two requester ports, the memory controller side and the busy flag.
// The arbiter uses the slave modport; the environment driving it uses master.
interface main_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_write;
    logic [ADDR_WIDTH-1:0] req0_address;
    logic [DATA_WIDTH-1:0] req0_write_data;
    logic                  req0_ready;
    logic                  req0_done;
    logic [DATA_WIDTH-1:0] req0_read_data;
    logic                  req0_error;

    logic                  req1_valid;
    logic                  req1_write;
    logic [ADDR_WIDTH-1:0] req1_address;
    logic [DATA_WIDTH-1:0] req1_write_data;
    logic                  req1_ready;
    logic                  req1_done;
    logic [DATA_WIDTH-1:0] req1_read_data;
    logic                  req1_error;

    logic                  mem_read_request;
    logic                  mem_write_request;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_ready;

    logic                  busy;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_write_data,
        output req0_ready, req0_done, req0_read_data, req0_error,
        input  req1_valid, req1_write, req1_address, req1_write_data,
        output req1_ready, req1_done, req1_read_data, req1_error,
        output mem_read_request, mem_write_request, mem_address, mem_write_data,
        input  mem_read_data, mem_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_write_data,
        input  req0_ready, req0_done, req0_read_data, req0_error,
        output req1_valid, req1_write, req1_address, req1_write_data,
        input  req1_ready, req1_done, req1_read_data, req1_error,
        input  mem_read_request, mem_write_request, mem_address, mem_write_data,
        output mem_read_data, mem_ready,
        input  busy
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter sharing the single-ported main memory controller between the
// cache fill path (port 0) and the write-back path (port 1), one transaction at a time.
module main_memory_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    main_memory_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT,
        CAPTURE,
        RESPOND
    } state_t;

    state_t                state;
    logic                  rr;
    logic                  owner;
    logic                  is_write;
    logic [CNT_W-1:0]      wait_cnt;

    logic                  any_valid;
    logic                  grant;
    logic                  grant_write;
    logic [ADDR_WIDTH-1:0] grant_address;
    logic [DATA_WIDTH-1:0] grant_write_data;

    // The rr pointer only matters when both ports are asking at once.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = rr;
        end else begin
            grant = bus.req1_valid;
        end
        grant_write      = grant ? bus.req1_write      : bus.req0_write;
        grant_address    = grant ? bus.req1_address    : bus.req0_address;
        grant_write_data = grant ? bus.req1_write_data : bus.req0_write_data;
    end

    // Gated with reset so nothing is accepted while the block is held in reset.
    assign bus.req0_ready = ~reset & (state == IDLE) & any_valid & ~grant;
    assign bus.req1_ready = ~reset & (state == IDLE) & any_valid &  grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= IDLE;
            rr                    <= 1'b0;
            owner                 <= 1'b0;
            is_write              <= 1'b0;
            wait_cnt              <= '0;
            bus.mem_read_request  <= 1'b0;
            bus.mem_write_request <= 1'b0;
            bus.mem_address       <= '0;
            bus.mem_write_data    <= '0;
            bus.req0_done         <= 1'b0;
            bus.req1_done         <= 1'b0;
            bus.req0_error        <= 1'b0;
            bus.req1_error        <= 1'b0;
            bus.req0_read_data    <= '0;
            bus.req1_read_data    <= '0;
            bus.busy              <= 1'b0;
        end else begin
            bus.mem_read_request  <= 1'b0;
            bus.mem_write_request <= 1'b0;
            bus.req0_done         <= 1'b0;
            bus.req1_done         <= 1'b0;
            bus.req0_error        <= 1'b0;
            bus.req1_error        <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner                 <= grant;
                        is_write              <= grant_write;
                        bus.mem_address       <= grant_address;
                        bus.mem_write_data    <= grant_write_data;
                        bus.mem_read_request  <= ~grant_write;
                        bus.mem_write_request <= grant_write;
                        bus.busy              <= 1'b1;
                        state                 <= REQUEST;
                    end
                end

                REQUEST: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (bus.mem_ready) begin
                        wait_cnt <= '0;
                        if (is_write) begin
                            bus.req0_done <= ~owner;
                            bus.req1_done <= owner;
                            state         <= RESPOND;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt       <= '0;
                        bus.req0_done  <= ~owner;
                        bus.req1_done  <= owner;
                        bus.req0_error <= ~owner;
                        bus.req1_error <= owner;
                        state          <= RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // Memory data lands on the edge after mem_ready, i.e. at the end of this cycle.
                CAPTURE: begin
                    if (owner) begin
                        bus.req1_read_data <= bus.mem_read_data;
                    end else begin
                        bus.req0_read_data <= bus.mem_read_data;
                    end
                    bus.req0_done <= ~owner;
                    bus.req1_done <= owner;
                    state         <= RESPOND;
                end

                RESPOND: begin
                    rr       <= ~owner;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Scoreboard bench for main_memory_arbiter: accepts push expected completions and memory
// pulses; a monitor and a memory model pop and compare them as the DUT produces them.
module tb_main_memory_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    main_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    main_memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] rd;
        bit            err;
        bit            wr;
        int            cyc;
    } resp_t;

    typedef struct {
        int            cyc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } pulse_t;

    resp_t         sb[$];
    pulse_t        pq[$];
    int            grants[$];
    logic [DW-1:0] model_rd[2];
    logic [DW-1:0] mem[256];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit stray = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input int port, input bit v, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (port == 0) begin
            bus.req0_valid = v; bus.req0_write = wr;
            bus.req0_address = a; bus.req0_write_data = wd;
        end else begin
            bus.req1_valid = v; bus.req1_write = wr;
            bus.req1_address = a; bus.req1_write_data = wd;
        end
    endtask

    // Called at posedge+1; holds valid until accepted, records what must follow.
    task automatic issue(input int port, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input bit exp_err);
        int lat;
        int n;
        bit got;
        lat = exp_err ? TO + 2 : (wr ? 3 : 4);
        got = 1'b0;
        n = 0;
        drive(port, 1'b1, wr, a, wd);
        while (!got && n < 200) begin
            #1;
            if ((port == 0 && bus.req0_ready) || (port == 1 && bus.req1_ready)) begin
                got = 1'b1;
                sb.push_back('{port, exp_rd, exp_err, wr, cyc + lat});
                pq.push_back('{cyc + 1, wr, a, wd});
                grants.push_back(port);
            end
            @(posedge clk); #1;
            n++;
        end
        drive(port, 1'b0, 1'b0, '0, '0);
        checks++;
        if (got) passes++;
        else $display("FAIL accept_port%0d: no ready after %0d cycles", port, n);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() == 0) passes++;
        else begin
            $display("FAIL drain: %0d responses still outstanding", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done,
                             bus.req0_error, bus.req1_error, bus.mem_read_request,
                             bus.mem_write_request, bus.busy}, 64'd0);
        chk({tag, "_rd0"}, bus.req0_read_data, 64'd0);
        chk({tag, "_rd1"}, bus.req1_read_data, 64'd0);
        chk({tag, "_addr"}, bus.mem_address, 64'd0);
        chk({tag, "_wdata"}, bus.mem_write_data, 64'd0);
    endtask

    // Memory controller model: ready one cycle after a request, read data one cycle later.
    initial begin
        bit            ready_next;
        bit            data_next;
        bit            last_wr;
        logic [AW-1:0] last_addr;
        pulse_t        p;
        ready_next = 1'b0;
        data_next = 1'b0;
        last_wr = 1'b0;
        last_addr = '0;
        bus.mem_ready = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ready_next = 1'b0;
                data_next = 1'b0;
                bus.mem_ready = 1'b0;
            end else begin
                bus.mem_ready = stray;
                if (data_next) begin
                    bus.mem_read_data = mem[last_addr[7:0]];
                    data_next = 1'b0;
                end
                if (ready_next) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_read_data = 32'hDEAD_BEEF;
                    data_next = !last_wr;
                    ready_next = 1'b0;
                end
                if (bus.mem_read_request || bus.mem_write_request) begin
                    chk("pulse_exclusive", bus.mem_read_request & bus.mem_write_request, 64'd0);
                    if (pq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_pulse: rd=%0b wr=%0b at cycle %0d, none required",
                                 bus.mem_read_request, bus.mem_write_request, cyc);
                    end else begin
                        p = pq.pop_front();
                        chk("pulse_cycle", cyc, p.cyc);
                        chk("pulse_type", bus.mem_write_request, p.wr);
                        chk("pulse_addr", bus.mem_address, p.addr);
                        if (p.wr) chk("pulse_wdata", bus.mem_write_data, p.wd);
                    end
                    last_addr = bus.mem_address;
                    last_wr = bus.mem_write_request;
                    if (bus.mem_write_request) mem[bus.mem_address[7:0]] = bus.mem_write_data;
                    if (!stall) ready_next = 1'b1;
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        resp_t r;
        int    seen;
        forever begin
            @(posedge clk); #1;
            if (!reset && (bus.req0_done || bus.req1_done)) begin
                chk("done_exclusive", bus.req0_done & bus.req1_done, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b at cycle %0d, none required",
                             bus.req0_done, bus.req1_done, cyc);
                end else begin
                    r = sb.pop_front();
                    seen = bus.req1_done ? 1 : 0;
                    chk("done_port", seen, r.port);
                    chk("done_cycle", cyc, r.cyc);
                    chk("done_error", seen == 1 ? bus.req1_error : bus.req0_error, r.err);
                    if (!r.err && !r.wr) model_rd[r.port] = r.rd;
                    chk("read_data", seen == 1 ? bus.req1_read_data : bus.req0_read_data,
                        model_rd[r.port]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        exp_g = '{0, 1, 0, 1};
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        model_rd[0] = '0;
        model_rd[1] = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
        mem[8'h10] = 32'hA5;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Plain read and write, then read back what was written.
        issue(0, 1'b0, 16'h10, '0, 32'hA5, 1'b0);
        drain();
        issue(1, 1'b1, 16'h20, 32'h5A, '0, 1'b0);
        drain();
        issue(1, 1'b0, 16'h20, '0, 32'h5A, 1'b0);
        drain();

        // Both ports asking continuously.
        grants.delete();
        fork
            begin
                issue(0, 1'b0, 16'h10, '0, 32'hA5, 1'b0);
                issue(0, 1'b0, 16'h30, '0, 32'h1234, 1'b0);
            end
            begin
                issue(1, 1'b1, 16'h30, 32'h1234, '0, 1'b0);
                issue(1, 1'b0, 16'h20, '0, 32'h5A, 1'b0);
            end
        join
        drain();
        chk("grant_count", grants.size(), 64'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], exp_g[i]);

        // Memory never answers: error completion, read data untouched, then normal service.
        stall = 1'b1;
        issue(0, 1'b0, 16'h40, '0, '0, 1'b1);
        drain();
        stall = 1'b0;
        issue(0, 1'b0, 16'h10, '0, 32'hA5, 1'b0);
        drain();

        // Reset while waiting on memory.
        stall = 1'b1;
        issue(1, 1'b0, 16'h20, '0, '0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("busy_in_wait", bus.busy, 64'd1);
        reset = 1'b1;
        #1;
        check_zero("reset_in_wait");
        sb.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("idle_after_reset", bus.busy, 64'd0);
        issue(1, 1'b0, 16'h10, '0, 32'hA5, 1'b0);
        drain();

        // Stray mem_ready while idle, then a lone requester.
        stray = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("stray_busy", bus.busy, 64'd0);
        stray = 1'b0;
        @(posedge clk); #1;
        issue(1, 1'b1, 16'h50, 32'hC3, '0, 1'b0);
        drain();
        issue(0, 1'b0, 16'h50, '0, 32'hC3, 1'b0);
        drain();

        chk("pulses_outstanding", pq.size(), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
